main_mem_responder: RTL and testbench



---
 rtl/main_mem_responder.sv | 122 ++++++++++++
 tb/tb_main_mem_responder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/main_mem_responder.sv
// main_mem_responder: RAM-side responder for the write-back cache, with a fixed read latency and a write buffer.
// Define MAIN_MEM_WB_FORWARD_EN to forward reads from the write buffer instead of draining it before each read.
module main_mem_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_DEPTH    = 4096,
  parameter int READ_LATENCY = 3,
  parameter int WB_DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        re_from_ram,
  input  logic [ADDR_WIDTH-1:0]       addr,
  output logic [DATA_WIDTH-1:0]       rd_from_ram,
  output logic                        rd_valid,
  input  logic                        we_to_ram,
  input  logic [DATA_WIDTH-1:0]       wd_to_ram,
  input  logic [ADDR_WIDTH-1:0]       w_addr_to_ram,
  output logic                        stall,
  output logic [$clog2(WB_DEPTH):0]   wb_count,
  output logic                        wb_overflow
);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = $clog2(READ_LATENCY + 1);
`ifdef MAIN_MEM_WB_FORWARD_EN
  localparam int BW = ADDR_WIDTH - 2;
`else
  localparam int BW = IW;
`endif
  typedef enum logic [1:0] {IDLE, DRAIN, READ_WAIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] raddr_q, raddr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, lookup;
  logic rvalid_q, rvalid_d, ovf_q, ovf_d;
  logic full, push, pop, unused_bits;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [BW-1:0] wb_addr_q [WB_DEPTH];
  logic [DATA_WIDTH-1:0] wb_data_q [WB_DEPTH];
  assign unused_bits = ^{addr, w_addr_to_ram};
  // Youngest buffered match wins; a push in the lookup cycle is younger still.
  always_comb begin
    lookup = mem[raddr_q[IW-1:0]];
`ifdef MAIN_MEM_WB_FORWARD_EN
    for (int k = 0; k < WB_DEPTH; k++)
      if ((PW+1)'(k) < count_q && wb_addr_q[rd_ptr_q + PW'(k)] == raddr_q)
        lookup = wb_data_q[rd_ptr_q + PW'(k)];
    if (push && w_addr_to_ram[BW+1:2] == raddr_q) lookup = wd_to_ram;
`endif
  end
  always_comb begin
    full = count_q == (PW+1)'(WB_DEPTH);
    push = we_to_ram & ~full;
    pop = count_q != '0 && (state_q == DRAIN || (state_q == IDLE && !re_from_ram));
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    ovf_d = ovf_q | (we_to_ram & full);
    state_d = state_q;
    cnt_d = cnt_q;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      IDLE: if (re_from_ram) begin
        raddr_d = addr[BW+1:2];
        cnt_d = CW'(READ_LATENCY - 1);
`ifdef MAIN_MEM_WB_FORWARD_EN
        state_d = READ_WAIT;
`else
        state_d = (count_q != '0 || push) ? DRAIN : READ_WAIT;
`endif
      end
      DRAIN: state_d = count_d == '0 ? READ_WAIT : DRAIN;
      READ_WAIT: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else begin
        rdata_d = lookup;
        rvalid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      raddr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      raddr_q <= raddr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      wb_addr_q[wr_ptr_q] <= w_addr_to_ram[BW+1:2];
      wb_data_q[wr_ptr_q] <= wd_to_ram;
    end
    if (rst_n && pop) mem[wb_addr_q[rd_ptr_q][IW-1:0]] <= wb_data_q[rd_ptr_q];
  end
  assign rd_from_ram = rdata_q;
  assign rd_valid = rvalid_q;
  assign stall = (state_q != IDLE) | full;
  assign wb_count = count_q;
  assign wb_overflow = ovf_q;
endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: directed stimulus with a response scoreboard for main_mem_responder.
module tb_main_mem_responder;
  logic clk = 1'b0, rst_n = 1'b0, re = 1'b0, we = 1'b0;
  logic [31:0] a = '0, wd = '0, wa = '0;
  logic [31:0] rd;
  logic rv, stall, ovf;
  logic [2:0] cnt;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
`ifdef MAIN_MEM_WB_FORWARD_EN
  localparam int SAME_LAT = 3;
`else
  localparam int SAME_LAT = 4;
`endif
  always #5 clk = ~clk;
  main_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .re_from_ram(re), .addr(a), .rd_from_ram(rd), .rd_valid(rv),
    .we_to_ram(we), .wd_to_ram(wd), .w_addr_to_ram(wa), .stall(stall), .wb_count(cnt),
    .wb_overflow(ovf)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(negedge clk) if (rv === 1'b1) begin
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected rd_valid: got data %h with no response expected", rd);
    end else chk("rd_data", rd, exp_q.pop_front());
  end
  task automatic cyc(input logic r, input logic [31:0] ra, input logic w, input logic [31:0] d, input logic [31:0] wadr);
    re = r; a = ra; we = w; wd = d; wa = wadr;
    @(posedge clk);
    @(negedge clk);
    re = 1'b0; we = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0, '0, '0);
  endtask
  task automatic rd_plain(input logic [31:0] ra, input logic [31:0] e);
    exp_q.push_back(e);
    cyc(1'b1, ra, 1'b0, '0, '0);
    idle(4);
  endtask
  task automatic rd_timed(input string n, input logic [31:0] ra, input logic w, input logic [31:0] d, input int lat, input logic [31:0] e);
    exp_q.push_back(e);
    cyc(1'b1, ra, w, d, ra);
    for (int k = 1; k <= lat; k++) begin
      chk({n, " stall busy"}, stall, 1);
      cyc(1'b0, '0, 1'b0, '0, '0);
      chk({n, " rd_valid timing"}, rv, k == lat);
    end
    chk({n, " stall released"}, stall, 0);
  endtask
  initial begin
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    chk("reset stall", stall, 0);
    chk("reset rd_valid", rv, 0);
    chk("reset wb_count", cnt, 0);
    chk("reset wb_overflow", ovf, 0);
    // preload array through the write buffer
    cyc(1'b0, '0, 1'b1, 32'hDEADBEEF, 32'h100);
    chk("push count", cnt, 1);
    cyc(1'b0, '0, 1'b1, 32'hA5A5A5A5, 32'h500);
    chk("push+pop count", cnt, 1);
    idle(2);
    chk("preload drained", cnt, 0);
    rd_timed("read 0x100", 32'h100, 1'b0, '0, 3, 32'hDEADBEEF);
    rd_timed("evict+read 0x200", 32'h200, 1'b1, 32'hCAFEF00D, SAME_LAT, 32'hCAFEF00D);
    idle(2);
    chk("after 0x200 drained", cnt, 0);
    // fill the buffer around an in-flight read, then overflow it
    exp_q.push_back(32'hDEADBEEF);
    cyc(1'b1, 32'h100, 1'b0, '0, '0);
    cyc(1'b0, '0, 1'b1, 32'h11, 32'h400);
    cyc(1'b0, '0, 1'b1, 32'h22, 32'h404);
    cyc(1'b0, '0, 1'b1, 32'h33, 32'h408);
    exp_q.push_back(32'h44);
    cyc(1'b1, 32'h40C, 1'b1, 32'h44, 32'h40C);
    chk("full wb_count", cnt, 4);
    chk("full stall", stall, 1);
    chk("overflow before drop", ovf, 0);
    cyc(1'b0, '0, 1'b1, 32'h55, 32'h500);
    chk("overflow set", ovf, 1);
    idle(10);
    chk("overflow drained", cnt, 0);
    chk("overflow idle stall", stall, 0);
    chk("overflow sticky", ovf, 1);
    rd_plain(32'h400, 32'h11);
    rd_plain(32'h404, 32'h22);
    rd_plain(32'h408, 32'h33);
    rd_plain(32'h40C, 32'h44);
    rd_plain(32'h500, 32'hA5A5A5A5);
    // two buffered writes to one word; the younger must win
    exp_q.push_back(32'hDEADBEEF);
    cyc(1'b1, 32'h100, 1'b0, '0, '0);
    cyc(1'b0, '0, 1'b1, 32'h1, 32'h300);
    cyc(1'b0, '0, 1'b1, 32'h2, 32'h300);
    idle(1);
    exp_q.push_back(32'h2);
    cyc(1'b1, 32'h300, 1'b0, '0, '0);
    idle(8);
    chk("rd_from_ram holds", rd, 32'h2);
    chk("rd_valid low between responses", rv, 0);
    // reset one cycle after a read is accepted
    cyc(1'b1, 32'h100, 1'b1, 32'h66, 32'h600);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk("mid-read reset rd_valid", rv, 0);
    chk("mid-read reset rd_from_ram", rd, 0);
    chk("mid-read reset stall", stall, 0);
    chk("mid-read reset wb_count", cnt, 0);
    chk("mid-read reset wb_overflow", ovf, 0);
    idle(6);
    rd_timed("read after reset", 32'h100, 1'b0, '0, 3, 32'hDEADBEEF);
    idle(3);
    chk("responses outstanding", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
